// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: sweeps a 32-bit nonce range through an external sha256 core
// and stops on the first hash <= target, range end, core timeout or abort.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   go_i, abort_i         start-sweep pulse, stop-sweep request
//   tmpl_i, nonce_start_i, nonce_end_i, target_i   sweep setup, sampled on accepted go
//   core_start_o, core_data_o                      request to the core
//   core_done_i, core_hash_i                       response from the core
//   busy_o, done_o                                 activity, one-cycle completion pulse
//   found_o, exhausted_o, timeout_err_o, aborted_o sticky status
//   found_nonce_o, found_hash_o                    winning result
//   cur_nonce_o, attempts_o                        progress
module nonce_sweep_ctrl #(
  parameter int unsigned NONCE_WORD = 3,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go_i,
  input  logic         abort_i,
  input  logic [511:0] tmpl_i,
  input  logic [31:0]  nonce_start_i,
  input  logic [31:0]  nonce_end_i,
  input  logic [255:0] target_i,
  output logic         core_start_o,
  output logic [511:0] core_data_o,
  input  logic         core_done_i,
  input  logic [255:0] core_hash_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         found_o,
  output logic         exhausted_o,
  output logic         timeout_err_o,
  output logic         aborted_o,
  output logic [31:0]  found_nonce_o,
  output logic [255:0] found_hash_o,
  output logic [31:0]  cur_nonce_o,
  output logic [31:0]  attempts_o
);

  localparam int unsigned NONCE_LO = NONCE_WORD * 32;
  localparam int unsigned TMO_W    = 32;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_e;

  state_e         state_q;
  logic [511:0]   tmpl_q;
  logic [31:0]    nonce_end_q;
  logic [255:0]   target_q;
  logic [255:0]   hash_q;
  logic [TMO_W-1:0] tmo_q;
  logic           abort_pend_q;
  logic           core_start_q;
  logic [511:0]   core_data_q;
  logic           busy_q;
  logic           done_q;
  logic           found_q;
  logic           exhausted_q;
  logic           timeout_err_q;
  logic           aborted_q;
  logic [31:0]    found_nonce_q;
  logic [255:0]   found_hash_q;
  logic [31:0]    cur_nonce_q;
  logic [31:0]    attempts_q;
  logic [511:0]   issue_blk_d;

  // Template with the nonce word substituted.
  always_comb begin
    issue_blk_d = tmpl_q;
    issue_blk_d[NONCE_LO +: 32] = cur_nonce_q;
  end

  // Controller FSM; busy/done are updated on each transition so they track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tmpl_q        <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      tmo_q         <= '0;
      abort_pend_q  <= 1'b0;
      core_start_q  <= 1'b0;
      core_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      aborted_q     <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      cur_nonce_q   <= '0;
      attempts_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // go wins over a simultaneous abort; abort alone is ignored here.
          if (go_i) begin
            tmpl_q        <= tmpl_i;
            nonce_end_q   <= nonce_end_i;
            target_q      <= target_i;
            cur_nonce_q   <= nonce_start_i;
            attempts_q    <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            aborted_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            abort_pend_q  <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_data_q  <= issue_blk_d;
          core_start_q <= 1'b1;
          tmo_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (abort_i) abort_pend_q <= 1'b1;
          if (core_done_i) begin
            hash_q     <= core_hash_i;
            attempts_q <= attempts_q + 32'd1;
            // A pending abort skips the compare entirely.
            if (abort_pend_q || abort_i) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_CHECK;
            end
          end else if (tmo_q == TMO_LAST) begin
            timeout_err_q <= 1'b1;
            if (abort_pend_q || abort_i) aborted_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_CHECK: begin
          if (hash_q <= target_q) begin
            found_q       <= 1'b1;
            found_nonce_q <= cur_nonce_q;
            found_hash_q  <= hash_q;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end else if (abort_i || abort_pend_q) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (cur_nonce_q == nonce_end_q) begin
            exhausted_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cur_nonce_q <= cur_nonce_q + 32'd1;
            state_q     <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_start_o  = core_start_q;
  assign core_data_o   = core_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign exhausted_o   = exhausted_q;
  assign timeout_err_o = timeout_err_q;
  assign aborted_o     = aborted_q;
  assign found_nonce_o = found_nonce_q;
  assign found_hash_o  = found_hash_q;
  assign cur_nonce_o   = cur_nonce_q;
  assign attempts_o    = attempts_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: table of sweeps against a 64-cycle core model,
// plus hand-written timeout, abort and mid-sweep reset sequences.
module tb_nonce_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1, go = 1'b0, abort = 1'b0;
  logic [511:0] tmpl = {16{32'hA5C3_0F1E}};
  logic [31:0]  nstart = '0, nend = '0;
  logic [255:0] target = '0;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '1;

  logic         core_start, busy, done, found, exhausted, timeout_err, aborted;
  logic [511:0] core_data;
  logic [31:0]  found_nonce, cur_nonce, attempts;
  logic [255:0] found_hash;

  logic         t_core_start, t_busy, t_done, t_found, t_exhausted, t_timeout_err, t_aborted;
  logic [511:0] t_core_data;
  logic [31:0]  t_found_nonce, t_cur_nonce, t_attempts;
  logic [255:0] t_found_hash;

  nonce_sweep_ctrl dut (
    .clk(clk), .reset(reset), .go_i(go), .abort_i(abort), .tmpl_i(tmpl),
    .nonce_start_i(nstart), .nonce_end_i(nend), .target_i(target),
    .core_start_o(core_start), .core_data_o(core_data),
    .core_done_i(core_done), .core_hash_i(core_hash),
    .busy_o(busy), .done_o(done), .found_o(found), .exhausted_o(exhausted),
    .timeout_err_o(timeout_err), .aborted_o(aborted),
    .found_nonce_o(found_nonce), .found_hash_o(found_hash),
    .cur_nonce_o(cur_nonce), .attempts_o(attempts)
  );

  // Second instance with a short timeout and a core that never answers.
  nonce_sweep_ctrl #(.NONCE_WORD(3), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .go_i(go), .abort_i(abort), .tmpl_i(tmpl),
    .nonce_start_i(nstart), .nonce_end_i(nend), .target_i(target),
    .core_start_o(t_core_start), .core_data_o(t_core_data),
    .core_done_i(1'b0), .core_hash_i(256'd0),
    .busy_o(t_busy), .done_o(t_done), .found_o(t_found), .exhausted_o(t_exhausted),
    .timeout_err_o(t_timeout_err), .aborted_o(t_aborted),
    .found_nonce_o(t_found_nonce), .found_hash_o(t_found_hash),
    .cur_nonce_o(t_cur_nonce), .attempts_o(t_attempts)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: fixed latency, hash 1 for nonce 7 when match_en, else a large value.
  bit          core_en = 1'b1;
  bit          match_en = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] lat_nonce = '0;

  function automatic logic [255:0] hash_of(input logic [31:0] n, input bit m);
    if (m && n == 32'd7) return 256'd1;
    return {n | 32'h8000_0000, 224'd0};
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        core_done <= 1'b1;
        core_hash <= hash_of(lat_nonce, match_en);
      end
    end
    if (core_start && core_en) begin
      lat_cnt   <= 64;
      lat_nonce <= core_data[96 +: 32];
    end
  end

  // Monitor: issued nonces, done pulses, block contents, per-nonce overhead.
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done = -1;
  logic [31:0] issued[$];
  logic [511:0] exp_blk;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (core_done) last_done = cyc;
    if (core_start) begin
      issued.push_back(core_data[96 +: 32]);
      exp_blk = tmpl;
      exp_blk[96 +: 32] = core_data[96 +: 32];
      chk("core_data", core_data, exp_blk);
      if (last_done >= 0) chk("overhead", 512'(cyc - last_done), 512'(3));
    end
  end

  typedef struct {
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    bit           match;
    bit           go_abort;
    bit           exp_found;
    bit           exp_exh;
    logic [31:0]  exp_att;
    logic [31:0]  exp_cur;
    logic [31:0]  exp_fn;
  } row_t;

  row_t rows[5];

  task automatic start_sweep(input logic [31:0] ns, input logic [31:0] ne,
                             input logic [255:0] tgt, input bit ab);
    @(negedge clk);
    nstart = ns; nend = ne; target = tgt; go = 1'b1; abort = ab;
    last_done = -1; done_cnt = 0; issued.delete();
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 512'(done), 512'(1));
    chk("busy_in_done", 512'(busy), 512'(1));
    @(negedge clk);
    chk("busy_after_done", 512'(busy), 512'(0));
    @(negedge clk);
    chk("done_pulses", 512'(done_cnt), 512'(1));
  endtask

  task automatic wait_issued(input int cnt);
    int n = 0;
    while (issued.size() < cnt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("issued_reached", 512'(issued.size() >= cnt), 512'(1));
  endtask

  task automatic run_row(input row_t r);
    logic [31:0] nx;
    core_en = 1'b1;
    match_en = r.match;
    start_sweep(r.ns, r.ne, r.tgt, r.go_abort);
    wait_done(2000);
    chk("found", 512'(found), 512'(r.exp_found));
    chk("exhausted", 512'(exhausted), 512'(r.exp_exh));
    chk("timeout_err", 512'(timeout_err), 512'(0));
    chk("aborted", 512'(aborted), 512'(0));
    chk("attempts", 512'(attempts), 512'(r.exp_att));
    chk("cur_nonce", 512'(cur_nonce), 512'(r.exp_cur));
    if (r.exp_found) begin
      chk("found_nonce", 512'(found_nonce), 512'(r.exp_fn));
      chk("found_hash", 512'(found_hash), 512'(hash_of(r.exp_fn, r.match)));
    end
    chk("starts", 512'(issued.size()), 512'(r.exp_att));
    nx = r.ns;
    foreach (issued[k]) begin
      chk("issued_nonce", 512'(issued[k]), 512'(nx));
      nx = nx + 32'd1;
    end
  endtask

  initial begin
    int n;
    rows[0] = '{32'd5, 32'd9, 256'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd9, 32'd0};
    rows[1] = '{32'd5, 32'd9, 256'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd7, 32'd7};
    rows[2] = '{32'hFFFF_FFFE, 32'd1, 256'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 32'd1, 32'd0};
    rows[3] = '{32'd3, 32'd3, 256'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd3, 32'd0};
    rows[4] = '{32'd5, 32'd9, '1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd5, 32'd5};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_core_start", 512'(core_start), 512'(0));
    chk("rst_core_data", core_data, 512'(0));
    chk("rst_flags", 512'({found, exhausted, timeout_err, aborted}), 512'(0));
    chk("rst_counts", 512'({cur_nonce, attempts}), 512'(0));

    // abort alone in IDLE is ignored
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", 512'(busy), 512'(0));
    chk("idle_abort_flag", 512'(aborted), 512'(0));

    foreach (rows[i]) run_row(rows[i]);

    // Core silent: short-timeout instance and default instance both time out.
    core_en = 1'b0;
    start_sweep(32'd5, 32'd9, 256'd0, 1'b0);
    n = 0;
    while (!t_core_start && n < 10) begin @(negedge clk); n++; end
    chk("t_start_seen", 512'(t_core_start), 512'(1));
    n = 0;
    do begin @(negedge clk); n++; end while (!t_done && n < 40);
    chk("t_done_delay", 512'(n), 512'(16));
    chk("t_timeout_err", 512'(t_timeout_err), 512'(1));
    chk("t_busy_in_done", 512'(t_busy), 512'(1));
    @(negedge clk);
    chk("t_busy_after", 512'(t_busy), 512'(0));
    chk("t_attempts", 512'(t_attempts), 512'(0));
    chk("t_found", 512'(t_found), 512'(0));
    wait_done(1200);
    chk("tmo_err_1024", 512'(timeout_err), 512'(1));
    chk("tmo_attempts", 512'(attempts), 512'(0));
    core_en = 1'b1;

    // Abort during WAIT of the second nonce; a go in the same window is ignored.
    match_en = 1'b0;
    start_sweep(32'd5, 32'd9, 256'd0, 1'b0);
    wait_issued(2);
    repeat (10) @(negedge clk);
    nstart = 32'd100; go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_pending_flag", 512'(aborted), 512'(0));
    chk("abort_busy", 512'(busy), 512'(1));
    chk("abort_cur_nonce", 512'(cur_nonce), 512'(6));
    wait_done(500);
    chk("abort_aborted", 512'(aborted), 512'(1));
    chk("abort_found", 512'(found), 512'(0));
    chk("abort_exh", 512'(exhausted), 512'(0));
    chk("abort_attempts", 512'(attempts), 512'(2));
    repeat (80) @(negedge clk);
    chk("abort_starts", 512'(issued.size()), 512'(2));

    // Reset in WAIT; the late core_done must not revive the sweep.
    start_sweep(32'd5, 32'd9, 256'd0, 1'b0);
    wait_issued(1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_core_data", core_data, 512'(0));
    repeat (80) @(negedge clk);
    chk("mid_rst_busy_late", 512'(busy), 512'(0));
    chk("mid_rst_done_cnt", 512'(done_cnt), 512'(0));
    chk("mid_rst_flags", 512'({found, exhausted, timeout_err, aborted}), 512'(0));
    chk("mid_rst_counts", 512'({cur_nonce, attempts}), 512'(0));
    chk("mid_rst_starts", 512'(issued.size()), 512'(1));
    run_row(rows[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
